// File: rtl/sbox_layer_pkg.sv
// Shared constants and helpers for the PRESENT-style S-box layer and its pLayer partner.
// Holds the permutation sizes, the round-counter seed and the 4-bit S-box table.
package sbox_layer_pkg;

    localparam int          N_SBOX    = 11;
    localparam int          N_ROUNDS  = 45;
    localparam logic [5:0]  LFSR_SEED = 6'h05;

    function automatic logic [3:0] sbox_lookup(input logic [3:0] nibble);
        logic [3:0] sub;
        case (nibble)
            4'h0: sub = 4'hE;
            4'h1: sub = 4'hD;
            4'h2: sub = 4'hB;
            4'h3: sub = 4'h0;
            4'h4: sub = 4'h2;
            4'h5: sub = 4'h1;
            4'h6: sub = 4'h4;
            4'h7: sub = 4'hF;
            4'h8: sub = 4'h7;
            4'h9: sub = 4'hA;
            4'hA: sub = 4'h8;
            4'hB: sub = 4'h5;
            4'hC: sub = 4'h9;
            4'hD: sub = 4'hC;
            4'hE: sub = 4'h3;
            default: sub = 4'h6;
        endcase
        return sub;
    endfunction

    function automatic logic [5:0] bitrev6(input logic [5:0] value);
        logic [5:0] rev;
        for (int i = 0; i < 6; i++) begin
            rev[i] = value[5-i];
        end
        return rev;
    endfunction

    // Round-constant LFSR: shift left, feedback taps on bits 5 and 4.
    function automatic logic [5:0] lfsr_step(input logic [5:0] value);
        return {value[4:0], value[5] ^ value[4]};
    endfunction

endpackage

// File: rtl/sbox_layer_sbox4.sv
// Combinational 4-bit S-box; the byte layer instantiates one per nibble.
module sbox4
    import sbox_layer_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] sub
);

    assign sub = sbox_lookup(nibble);

endmodule

// File: rtl/sbox_layer.sv
// Byte-serial S-box layer: injects the round constant on the first and last byte of each
// round, substitutes both nibbles and hands the result to pLayer through a one-deep register.
module sbox_layer
    import sbox_layer_pkg::*;
#(
    parameter int         nSBox     = N_SBOX,
    parameter int         nRounds   = N_ROUNDS,
    parameter logic [5:0] LFSR_INIT = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  state_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  state_out,
    output logic [31:0] index,
    output logic        perm_done
);

    localparam int BW = (nSBox   > 1) ? $clog2(nSBox)   : 1;
    localparam int RW = (nRounds > 1) ? $clog2(nRounds) : 1;

    logic [BW-1:0] bcnt_reg, bcnt_next;
    logic [RW-1:0] rcnt_reg, rcnt_next;
    logic [5:0]    lfsr_reg, lfsr_next;
    logic          out_valid_reg;
    logic [7:0]    state_out_reg;
    logic [31:0]   index_reg;
    logic          perm_done_reg;

    logic          accept;
    logic          last_byte;
    logic          last_round;
    logic [7:0]    mixed;
    logic [7:0]    subbed;

    assign in_ready   = (!out_valid_reg || out_ready) && !start && !rst;
    assign accept     = in_valid && in_ready;
    assign last_byte  = (bcnt_reg == BW'(nSBox - 1));
    assign last_round = (rcnt_reg == RW'(nRounds - 1));

    // Round constant goes in before substitution; both injections apply if nSBox is 1.
    always_comb begin
        mixed = state_in;
        if (bcnt_reg == '0) begin
            mixed = mixed ^ {2'b00, lfsr_reg};
        end
        if (last_byte) begin
            mixed = mixed ^ {bitrev6(lfsr_reg), 2'b00};
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_nibble
            sbox4 u_sbox4 (
                .nibble (mixed[gi*4 +: 4]),
                .sub    (subbed[gi*4 +: 4])
            );
        end
    endgenerate

    // Counter/LFSR advance; start takes priority and never coincides with an acceptance.
    always_comb begin
        bcnt_next = bcnt_reg;
        rcnt_next = rcnt_reg;
        lfsr_next = lfsr_reg;
        if (start) begin
            bcnt_next = '0;
            rcnt_next = '0;
            lfsr_next = LFSR_INIT;
        end else if (accept) begin
            if (last_byte) begin
                bcnt_next = '0;
                if (last_round) begin
                    rcnt_next = '0;
                    lfsr_next = LFSR_INIT;
                end else begin
                    rcnt_next = rcnt_reg + 1'b1;
                    lfsr_next = lfsr_step(lfsr_reg);
                end
            end else begin
                bcnt_next = bcnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_reg      <= '0;
            rcnt_reg      <= '0;
            lfsr_reg      <= LFSR_INIT;
            out_valid_reg <= 1'b0;
            state_out_reg <= 8'h00;
            index_reg     <= 32'd0;
            perm_done_reg <= 1'b0;
        end else begin
            bcnt_reg      <= bcnt_next;
            rcnt_reg      <= rcnt_next;
            lfsr_reg      <= lfsr_next;
            perm_done_reg <= accept && last_byte && last_round;
            if (accept) begin
                out_valid_reg <= 1'b1;
                state_out_reg <= subbed;
                index_reg     <= 32'(bcnt_reg);
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign state_out = state_out_reg;
    assign index     = index_reg;
    assign perm_done = perm_done_reg;

endmodule

// File: tb/tb_sbox_layer.sv
// Randomised bench for sbox_layer against a behavioural model of the round/byte schedule.
module tb_sbox_layer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  state_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  state_out;
    logic [31:0] index;
    logic        perm_done;

    int total = 0;
    int bad   = 0;

    int SBOX_T [16] = '{14, 13, 11, 0, 2, 1, 4, 15, 7, 10, 8, 5, 9, 12, 3, 6};
    localparam int NS = 11;
    localparam int NR = 45;

    // Model state
    int m_bcnt, m_rcnt, m_lfsr;
    bit m_ov, m_done;
    int m_out, m_idx;

    sbox_layer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .index     (index),
        .perm_done (perm_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit exp_ready();
        return (!m_ov || out_ready) && !start && !rst;
    endfunction

    function automatic int bitrev(input int x);
        int r = 0;
        for (int k = 0; k < 6; k++) r |= ((x >> k) & 1) << (5 - k);
        return r;
    endfunction

    function automatic int subst(input int b);
        return (SBOX_T[(b >> 4) & 15] << 4) | SBOX_T[b & 15];
    endfunction

    task automatic drive(input bit iv, input logic [7:0] d, input bit ordy, input bit st, input bit r);
        in_valid  = iv;
        state_in  = d;
        out_ready = ordy;
        start     = st;
        rst       = r;
        #1;
    endtask

    // Advance one clock and move the model along with it.
    task automatic tick();
        bit acc;
        int b;
        acc = in_valid && exp_ready();
        b   = int'(state_in);
        @(posedge clk);
        if (rst) begin
            m_bcnt = 0; m_rcnt = 0; m_lfsr = 5;
            m_ov = 0; m_out = 0; m_idx = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (start) begin
                m_bcnt = 0; m_rcnt = 0; m_lfsr = 5;
            end
            if (acc) begin
                if (m_bcnt == 0)      b ^= m_lfsr;
                if (m_bcnt == NS - 1) b ^= (bitrev(m_lfsr) << 2);
                m_out  = subst(b & 255);
                m_idx  = m_bcnt;
                m_ov   = 1;
                m_done = (m_bcnt == NS - 1) && (m_rcnt == NR - 1);
                $display("xfer idx=%0d round=%0d in=%02h out=%02h", m_bcnt, m_rcnt, state_in, m_out);
                if (m_bcnt == NS - 1) begin
                    m_bcnt = 0;
                    if (m_rcnt == NR - 1) begin
                        m_rcnt = 0; m_lfsr = 5;
                    end else begin
                        m_rcnt++;
                        m_lfsr = ((m_lfsr << 1) & 63) | (((m_lfsr >> 5) ^ (m_lfsr >> 4)) & 1);
                    end
                end else begin
                    m_bcnt++;
                end
            end else if (out_ready) begin
                m_ov = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 8'hA5, 1, 1, 1);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0 || state_out !== 8'h00 || index !== 32'd0 || perm_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%b so=%02h idx=%0d pd=%b want 0 00 0 0",
                     out_valid, state_out, index, perm_done);
        end
        drive(0, 8'h00, 1, 0, 0);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [7:0] d;
        drive(0, 8'h00, 1, 1, 0);
        tick();
        for (int i = 0; i <= NS; i++) begin
            d = (i == 5) ? 8'h12 : (i == 0 || i == NS - 1 || i == NS) ? 8'h00 : 8'($urandom);
            drive(1, d, 1, 0, 0);
            tick();
            total++;
            if (out_valid !== 1'b1 || state_out !== 8'(m_out) || index !== 32'(m_idx)) begin
                bad++;
                $display("FAIL vec_model[%0d]: got ov=%b so=%02h idx=%0d want 1 %02h %0d",
                         i, out_valid, state_out, index, m_out, m_idx);
            end
            if (i == 0 || i == 5 || i == NS - 1 || i == NS) begin
                logic [7:0] want;
                want = (i == 0) ? 8'hE1 : (i == 5) ? 8'hDB : (i == NS - 1) ? 8'h8E : 8'hE8;
                total++;
                if (state_out !== want || index !== 32'(i % NS)) begin
                    bad++;
                    $display("FAIL vec_known[%0d]: got so=%02h idx=%0d want %02h %0d",
                             i, state_out, index, want, i % NS);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        drive(1, 8'($urandom), 1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'($urandom), 0, 0, 0);
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
            total++;
            if (out_valid !== 1'b1 || state_out !== 8'(m_out) || index !== 32'(m_idx)) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got ov=%b so=%02h idx=%0d want 1 %02h %0d",
                         i, out_valid, state_out, index, m_out, m_idx);
            end
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'($urandom), 1, 0, 0);
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL resume_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            total++;
            if (out_valid !== 1'b1 || state_out !== 8'(m_out) || index !== 32'(m_idx)) begin
                bad++;
                $display("FAIL resume_data[%0d]: got ov=%b so=%02h idx=%0d want 1 %02h %0d",
                         i, out_valid, state_out, index, m_out, m_idx);
            end
        end
    endtask

    task automatic test_full_perm();
        int pulses = 0;
        int where  = -1;
        drive(0, 8'h00, 1, 1, 0);
        tick();
        for (int i = 1; i <= NS * NR; i++) begin
            drive(1, 8'($urandom), 1, 0, 0);
            tick();
            if (perm_done === 1'b1) begin pulses++; where = i; end
            total++;
            if (out_valid !== 1'b1 || state_out !== 8'(m_out) || index !== 32'(m_idx) || perm_done !== m_done) begin
                bad++;
                $display("FAIL perm_stream[%0d]: got ov=%b so=%02h idx=%0d pd=%b want 1 %02h %0d %b",
                         i, out_valid, state_out, index, perm_done, m_out, m_idx, m_done);
            end
        end
        total++;
        if (pulses != 1 || where != 495) begin
            bad++;
            $display("FAIL perm_done_count: got pulses=%0d at=%0d want 1 at 495", pulses, where);
        end
        drive(1, 8'h00, 1, 0, 0);
        tick();
        total++;
        if (state_out !== 8'hE1 || index !== 32'd0 || perm_done !== 1'b0) begin
            bad++;
            $display("FAIL perm_reseed: got so=%02h idx=%0d pd=%b want E1 0 0", state_out, index, perm_done);
        end
    endtask

    task automatic test_start_mid_round();
        drive(0, 8'h00, 1, 1, 0);
        tick();
        for (int i = 0; i < 2 * NS + 4; i++) begin
            drive(1, 8'($urandom), 1, 0, 0);
            tick();
        end
        drive(1, 8'h77, 0, 1, 0);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL start_ready: got %b want 0", in_ready); end
        tick();
        total++;
        if (out_valid !== 1'b1 || state_out !== 8'(m_out) || index !== 32'(m_idx) || perm_done !== 1'b0) begin
            bad++;
            $display("FAIL start_keeps_pending: got ov=%b so=%02h idx=%0d pd=%b want 1 %02h %0d 0",
                     out_valid, state_out, index, perm_done, m_out, m_idx);
        end
        drive(1, 8'h00, 1, 0, 0);
        tick();
        total++;
        if (state_out !== 8'hE1 || index !== 32'd0 || perm_done !== 1'b0) begin
            bad++;
            $display("FAIL start_restart: got so=%02h idx=%0d pd=%b want E1 0 0", state_out, index, perm_done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
            total++;
            if (in_ready !== exp_ready()) begin
                bad++;
                $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, exp_ready());
            end
            tick();
            total++;
            if (out_valid !== m_ov || state_out !== 8'(m_out) || index !== 32'(m_idx) || perm_done !== m_done) begin
                bad++;
                $display("FAIL rand_out[%0d]: got ov=%b so=%02h idx=%0d pd=%b want %b %02h %0d %b",
                         i, out_valid, state_out, index, perm_done, m_ov, m_out, m_idx, m_done);
            end
        end
    endtask

    initial begin
        m_bcnt = 0; m_rcnt = 0; m_lfsr = 5;
        m_ov = 0; m_out = 0; m_idx = 0; m_done = 0;
        drive(0, 8'h00, 0, 0, 1);
        test_reset();
        test_vectors();
        test_backpressure();
        test_full_perm();
        test_start_mid_round();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
